// File: rtl/tawas_thread_sched_if.sv
// Issue/writeback bus between the Tawas thread scheduler and its surrounding pipeline.
// prio_mask exists only when TAWAS_SCHED_PRIO_EN is defined.
interface tawas_thread_sched_if;
    logic [31:0] thread_en_set;
    logic [31:0] thread_en_clr;
    logic        block_en;
    logic [4:0]  block_thread;
    logic        wake_en;
    logic [4:0]  wake_thread;
    logic        stall;
`ifdef TAWAS_SCHED_PRIO_EN
    logic [31:0] prio_mask;
`endif
    logic        thread_load_en;
    logic [4:0]  thread_load;
    logic        wb_valid;
    logic [4:0]  wb_thread;
    logic [31:0] thread_active;
    logic [31:0] thread_blocked;
    logic        idle;

`ifdef TAWAS_SCHED_PRIO_EN
    modport master (
        input  thread_en_set, thread_en_clr, block_en, block_thread,
               wake_en, wake_thread, stall, prio_mask,
        output thread_load_en, thread_load, wb_valid, wb_thread,
               thread_active, thread_blocked, idle
    );
    modport slave (
        output thread_en_set, thread_en_clr, block_en, block_thread,
               wake_en, wake_thread, stall, prio_mask,
        input  thread_load_en, thread_load, wb_valid, wb_thread,
               thread_active, thread_blocked, idle
    );
`else
    modport master (
        input  thread_en_set, thread_en_clr, block_en, block_thread,
               wake_en, wake_thread, stall,
        output thread_load_en, thread_load, wb_valid, wb_thread,
               thread_active, thread_blocked, idle
    );
    modport slave (
        output thread_en_set, thread_en_clr, block_en, block_thread,
               wake_en, wake_thread, stall,
        input  thread_load_en, thread_load, wb_valid, wb_thread,
               thread_active, thread_blocked, idle
    );
`endif
endinterface

// File: rtl/tawas_thread_sched.sv
// Barrel-thread issue scheduler: round-robin pick among 32 threads, issue strobe and writeback tag pipe.
// Optional priority pick enabled by defining TAWAS_SCHED_PRIO_EN.
module tawas_thread_sched #(
    parameter int unsigned PIPE_DEPTH = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    tawas_thread_sched_if.master  sched_io
);

    localparam int unsigned NT = 32;
    localparam int unsigned TW = 5;

    logic [NT-1:0]  active_q, active_d;
    logic [NT-1:0]  blocked_q, blocked_d;
    logic [NT-1:0]  inflight_q, inflight_d;
    logic [TW-1:0]  ptr_q, ptr_d;
    logic [TW-1:0]  load_q, load_d;
    logic           load_en_q, load_en_d;
    logic           idle_q, idle_d;
    logic [PIPE_DEPTH-1:0] wb_vld_q, wb_vld_d;
    logic [TW-1:0]  wb_thr_q [PIPE_DEPTH];
    logic [TW-1:0]  wb_thr_d [PIPE_DEPTH];

    logic [NT-1:0]  ready_c;
    logic [NT-1:0]  cand_c;
    logic           pick_vld_c;
    logic [TW-1:0]  pick_c;
    logic           issue_c;

    assign ready_c = active_q & ~blocked_q & ~inflight_q;

`ifdef TAWAS_SCHED_PRIO_EN
    // Priority threads share the round-robin pointer with the normal pool.
    assign cand_c = ((ready_c & sched_io.prio_mask) != '0) ? (ready_c & sched_io.prio_mask) : ready_c;
`else
    assign cand_c = ready_c;
`endif

    // First candidate after the pointer, pointer itself last.
    always_comb begin
        logic [TW-1:0] idx;
        idx        = '0;
        pick_vld_c = 1'b0;
        pick_c     = ptr_q;
        for (int unsigned k = 1; k <= NT; k++) begin
            idx = ptr_q + TW'(k);
            if (!pick_vld_c && cand_c[idx]) begin
                pick_vld_c = 1'b1;
                pick_c     = idx;
            end
        end
    end

    always_comb begin
        wb_vld_d    = '0;
        wb_vld_d[0] = load_en_q;
        wb_thr_d[0] = load_q;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
            wb_vld_d[i] = wb_vld_q[i-1];
            wb_thr_d[i] = wb_thr_q[i-1];
        end

        active_d = (active_q | sched_io.thread_en_set) & ~sched_io.thread_en_clr;

        // Wake is applied after block so it wins on a same-thread collision.
        blocked_d = blocked_q;
        if (sched_io.block_en && active_q[sched_io.block_thread])
            blocked_d[sched_io.block_thread] = 1'b1;
        if (sched_io.wake_en && active_q[sched_io.wake_thread])
            blocked_d[sched_io.wake_thread] = 1'b0;
        blocked_d = blocked_d & active_d;

        // Slot retires on the edge its writeback tag appears.
        inflight_d = inflight_q;
        if (wb_vld_d[PIPE_DEPTH-1])
            inflight_d[wb_thr_d[PIPE_DEPTH-1]] = 1'b0;

        issue_c   = pick_vld_c & ~sched_io.stall;
        load_en_d = issue_c;
        load_d    = load_q;
        ptr_d     = ptr_q;
        if (issue_c) begin
            load_d             = pick_c;
            ptr_d              = pick_c;
            inflight_d[pick_c] = 1'b1;
        end

        idle_d = (ready_c == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= NT'(1);
            blocked_q  <= '0;
            inflight_q <= '0;
            ptr_q      <= TW'(NT - 1);
            load_q     <= '0;
            load_en_q  <= 1'b0;
            idle_q     <= 1'b0;
            wb_vld_q   <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++)
                wb_thr_q[i] <= '0;
        end else begin
            active_q   <= active_d;
            blocked_q  <= blocked_d;
            inflight_q <= inflight_d;
            ptr_q      <= ptr_d;
            load_q     <= load_d;
            load_en_q  <= load_en_d;
            idle_q     <= idle_d;
            wb_vld_q   <= wb_vld_d;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++)
                wb_thr_q[i] <= wb_thr_d[i];
        end
    end

    assign sched_io.thread_load_en = load_en_q;
    assign sched_io.thread_load    = load_q;
    assign sched_io.wb_valid       = wb_vld_q[PIPE_DEPTH-1];
    assign sched_io.wb_thread      = wb_thr_q[PIPE_DEPTH-1];
    assign sched_io.thread_active  = active_q;
    assign sched_io.thread_blocked = blocked_q;
    assign sched_io.idle           = idle_q;

endmodule

// File: doc/tawas_thread_sched.md
Name: tawas_thread_sched

Overview:
- Barrel-thread issue scheduler for the Tawas core.
- Each cycle it picks one ready hardware thread, round-robin among 32, and drives the register file's thread-load port (thread_load_en / thread_load).
- Tracks per-thread enabled, blocked and in-flight state.
- Delays the issued thread ID through a pipe so writeback logic gets the matching wb_thread.

Parameters:
- PIPE_DEPTH, 3: cycles from issue (thread_load_en high) to wb_valid/wb_thread for that issue. Legal range 1..8.

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- thread_en_set  input  32  one-cycle pulse bits; set thread active
- thread_en_clr  input  32  one-cycle pulse bits; clear thread active
- block_en  input  1  mark block_thread blocked (outstanding bus op)
- block_thread  input  5  thread to block
- wake_en  input  1  clear blocked for wake_thread
- wake_thread  input  5  thread to wake
- stall  input  1  global hold; no issue this cycle
- thread_load_en  output  1  issue strobe to register file
- thread_load  output  5  issued thread ID
- wb_valid  output  1  thread_load_en delayed PIPE_DEPTH cycles
- wb_thread  output  5  thread_load delayed PIPE_DEPTH cycles
- thread_active  output  32  registered active mask
- thread_blocked  output  32  registered blocked mask
- idle  output  1  registered; no thread ready

Behaviour:
- Reset (async, rst_n low):
  - thread_active = 32'h1 (thread 0 boots); thread_blocked = 0; inflight = 0.
  - RR pointer = 31, so the first pick is thread 0.
  - thread_load_en = 0, thread_load = 0; all wb pipe stages invalid/0; wb_valid = 0, wb_thread = 0; idle = 0.
- ready[i] = active[i] & ~blocked[i] & ~inflight[i]. All terms are registered state.
- Pick (combinational from registered state):
  - Take the first ready thread scanning ptr+1, ptr+2, … with mod-32 wrap; ptr itself is checked last.
  - If no thread is ready, or stall = 1: no issue.
- Issue (registered, 1-cycle latency):
  - On the next edge: thread_load_en = 1, thread_load = pick, ptr = pick, inflight[pick] set.
  - Otherwise thread_load_en = 0; thread_load and ptr hold.
- Inflight clear:
  - inflight[t] clears on the edge where wb_valid goes high with wb_thread = t.
  - Minimum re-issue spacing for one thread is therefore PIPE_DEPTH+1 cycles. The regfile writeback latency is covered by this spacing.
- wb pipe:
  - PIPE_DEPTH-stage shift of {thread_load_en, thread_load}.
  - Shifts every cycle regardless of stall. Stall only suppresses new issue.
- Active update:
  - active <= (active | thread_en_set) & ~thread_en_clr. Clear wins on the same bit.
  - Clearing active also clears blocked for that thread.
  - An in-flight thread still completes its wb slot.
- Blocked update:
  - Block sets, wake clears.
  - Block and wake to the same thread in the same cycle: wake wins (thread ends unblocked).
  - Block or wake to an inactive thread is ignored.
- Timing of control inputs:
  - Block/enable changes at edge N affect the pick made in cycle N+1.
  - They appear on thread_load_en at edge N+2.
- idle <= (ready == 0), updated every cycle including during stall.
- Mid-operation reset: all in-flight wb slots are discarded; wb_valid = 0 immediately.

Optional Feature:
- Macro: TAWAS_SCHED_PRIO_EN.
- When defined:
  - Adds input prio_mask [31:0].
  - If (ready & prio_mask) is nonzero, the pick is the round-robin winner among those bits using the same shared pointer.
  - Otherwise the normal round-robin over ready applies.
- When undefined: the port is absent and the pick is pure round-robin.

Test Plan:
- Reset release, no other stimulus → thread 0 issues on edges 1, 1+(PIPE_DEPTH+1), …; wb_valid/wb_thread = 0 exactly PIPE_DEPTH cycles after each issue.
- thread_en_set = 32'hF after reset → issue order 0,1,2,3,0,1,… every cycle with PIPE_DEPTH = 3; no thread issues twice within 4 cycles.
- Threads 0–3 active; block_en with block_thread = 2 → thread 2 skipped (0,1,3,0,1,3); wake_en for thread 2 → it rejoins after thread 1.
- Same-cycle block_en and wake_en to thread 1 → thread_blocked[1] = 0; same-cycle set and clr to thread 5 → thread_active[5] = 0.
- stall = 1 for 5 cycles with 4 active threads → thread_load_en = 0 throughout; wb pipe drains; issue resumes from ptr+1.
- Clear all active → idle = 1 two cycles later; assert rst_n low mid-pipe → wb_valid = 0 immediately, thread_active = 32'h1.
